// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants for the MIPS32 datapath:
// fetch FSM states, redirect-source encoding and the default reset PC.
package mips_pkg;

   typedef enum logic [1:0] {
      S_BOOT,
      S_FETCH,
      S_HOLD
   } fetch_state_t;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_BR,
      SRC_J,
      SRC_JR
   } redir_src_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // J/JAL target: stays inside the current 256 MB region of the fetch pc.
   function automatic logic [31:0] jump_target(input logic [31:0] base_pc,
                                                input logic [25:0] idx);
      return {base_pc[31:28], idx, 2'b00};
   endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational redirect priority mux (jr > jump > branch) and target
// arithmetic for the fetch stage; holds no state.
module next_pc_sel
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        branch_taken,
   input  logic [31:0] branch_off_sh,
   input  logic        jump,
   input  logic [25:0] jump_idx,
   input  logic        jr,
   input  logic [31:0] jr_addr,
   output logic [31:0] target,
   output logic        redirect,
   output logic        misalign_raw
);

   redir_src_t src;

   always_comb begin
      src = SRC_NONE;
      if (jr)
         src = SRC_JR;
      else if (jump)
         src = SRC_J;
      else if (branch_taken)
         src = SRC_BR;
   end

   always_comb begin
      target       = pc;
      redirect     = 1'b0;
      misalign_raw = 1'b0;
      case (src)
         SRC_JR: begin
            // Low bits are forced to zero; the caller is told via misalign.
            target       = {jr_addr[31:2], 2'b00};
            redirect     = 1'b1;
            misalign_raw = (jr_addr[1:0] != 2'b00);
         end
         SRC_J: begin
            target   = jump_target(pc, jump_idx);
            redirect = 1'b1;
         end
         SRC_BR: begin
            // Fetch pc in the resolving cycle is already branch PC+4.
            target   = pc + branch_off_sh;
            redirect = 1'b1;
         end
         default: begin
            target   = pc;
            redirect = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register, fetch FSM and imem handshake for the MIPS32 fetch stage.
// Build option: define BRANCH_DELAY_SLOT_EN to keep the delay-slot fetch valid.
module fetch_pc_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_off_sh,
   input  logic        jump,
   input  logic [25:0] jump_idx,
   input  logic        jr,
   input  logic [31:0] jr_addr,
   input  logic        imem_ready,
   output logic        imem_req,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_valid,
   output logic        misalign
);

   fetch_state_t state_reg, state_next;
   logic [31:0]  pc_reg, pc_next;
   logic [31:0]  pend_pc_reg, pend_pc_next;
   logic         misalign_reg;

   logic [31:0]  target;
   logic         redirect;
   logic         misalign_raw;
   logic         advance;
   logic         kill;

   next_pc_sel u_next_pc_sel (
      .pc            (pc_reg),
      .branch_taken  (branch_taken),
      .branch_off_sh (branch_off_sh),
      .jump          (jump),
      .jump_idx      (jump_idx),
      .jr            (jr),
      .jr_addr       (jr_addr),
      .target        (target),
      .redirect      (redirect),
      .misalign_raw  (misalign_raw)
   );

   assign imem_req = (state_reg != S_BOOT);
   assign advance  = imem_req & imem_ready & ~stall;
   assign pc       = pc_reg;
   assign pc_plus4 = pc_reg + 32'd4;
   assign misalign = misalign_reg;

`ifdef BRANCH_DELAY_SLOT_EN
   assign kill = 1'b0;
`else
   assign kill = redirect | (state_reg == S_HOLD);
`endif

   assign fetch_valid = advance & ~kill;

   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      pend_pc_next = pend_pc_reg;
      case (state_reg)
         S_BOOT: begin
            if (redirect) begin
               pend_pc_next = target;
               state_next   = S_HOLD;
            end else begin
               state_next   = S_FETCH;
            end
         end
         S_FETCH: begin
            if (redirect) begin
               if (advance) begin
                  pc_next = target;
               end else begin
                  pend_pc_next = target;
                  state_next   = S_HOLD;
               end
            end else if (advance) begin
               pc_next = pc_plus4;
            end
         end
         S_HOLD: begin
            // A redirect arriving while held replaces the parked target.
            if (advance) begin
               pc_next    = redirect ? target : pend_pc_reg;
               state_next = S_FETCH;
            end else if (redirect) begin
               pend_pc_next = target;
            end
         end
         default: begin
            state_next = S_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_BOOT;
         pc_reg       <= RESET_PC;
         pend_pc_reg  <= 32'h0000_0000;
         misalign_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         pend_pc_reg  <= pend_pc_next;
         misalign_reg <= misalign_raw;
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit: reset, sequencing,
// redirects, stalled redirects, priority/misalign, wrap and reset-in-hold.
module tb_fetch_pc_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_off_sh;
   logic        jump;
   logic [25:0] jump_idx;
   logic        jr;
   logic [31:0] jr_addr;
   logic        imem_ready;
   logic        imem_req;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_valid;
   logic        misalign;

   int checks = 0;
   int errors = 0;

`ifdef BRANCH_DELAY_SLOT_EN
   localparam logic DS_VALID = 1'b1;
`else
   localparam logic DS_VALID = 1'b0;
`endif

   fetch_pc_unit dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_off_sh (branch_off_sh),
      .jump          (jump),
      .jump_idx      (jump_idx),
      .jr            (jr),
      .jr_addr       (jr_addr),
      .imem_ready    (imem_ready),
      .imem_req      (imem_req),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .fetch_valid   (fetch_valid),
      .misalign      (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_redirects();
      branch_taken = 1'b0;
      jump         = 1'b0;
      jr           = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; imem_ready = 1'b1;
      clear_redirects();
      branch_off_sh = 32'h0; jump_idx = 26'h0; jr_addr = 32'h0;
      repeat (3) tick();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
      checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b expected 0", fetch_valid); end
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", misalign); end
      rst = 1'b0;
      #1;
      $display("reset released: pc=%h imem_req=%b", pc, imem_req);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b expected 0", imem_req); end
      tick();
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", imem_req); end
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL seq0: got %h expected %h", pc, 32'h0); end
      checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_fv: got %b expected 1", fetch_valid); end
      tick();
      checks++; if (pc !== 32'h4) begin errors++; $display("FAIL seq4: got %h expected %h", pc, 32'h4); end
      tick();
      checks++; if (pc !== 32'h8) begin errors++; $display("FAIL seq8: got %h expected %h", pc, 32'h8); end
      $display("sequential: pc=%h", pc);
   endtask

   task automatic test_branch();
      branch_taken = 1'b1; branch_off_sh = 32'h10;
      #1;
      checks++; if (fetch_valid !== DS_VALID) begin errors++; $display("FAIL branch_fv: got %b expected %b", fetch_valid, DS_VALID); end
      tick();
      clear_redirects();
      #1;
      $display("branch: pc=%h", pc);
      checks++; if (pc !== 32'h18) begin errors++; $display("FAIL branch_pc: got %h expected %h", pc, 32'h18); end
      checks++; if (pc_plus4 !== 32'h1C) begin errors++; $display("FAIL branch_pc4: got %h expected %h", pc_plus4, 32'h1C); end
   endtask

   task automatic test_jump();
      jr = 1'b1; jr_addr = 32'h4000_0010;
      tick();
      clear_redirects();
      #1;
      checks++; if (pc !== 32'h4000_0010) begin errors++; $display("FAIL jr_pc: got %h expected %h", pc, 32'h4000_0010); end
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL jr_aligned: got %b expected 0", misalign); end
      jump = 1'b1; jump_idx = 26'h0000040;
      tick();
      clear_redirects();
      #1;
      $display("jump: pc=%h", pc);
      checks++; if (pc !== 32'h4000_0100) begin errors++; $display("FAIL jump_pc: got %h expected %h", pc, 32'h4000_0100); end
   endtask

   task automatic test_stalled_redirect();
      stall = 1'b1; jr = 1'b1; jr_addr = 32'h200;
      #1;
      checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_fv: got %b expected 0", fetch_valid); end
      tick();
      checks++; if (pc !== 32'h4000_0100) begin errors++; $display("FAIL stall_hold: got %h expected %h", pc, 32'h4000_0100); end
      jr = 1'b0; branch_taken = 1'b1; branch_off_sh = 32'h8;
      tick();
      clear_redirects();
      #1;
      checks++; if (pc !== 32'h4000_0100) begin errors++; $display("FAIL hold_pc: got %h expected %h", pc, 32'h4000_0100); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL hold_req: got %b expected 1", imem_req); end
      stall = 1'b0;
      #1;
      checks++; if (fetch_valid !== DS_VALID) begin errors++; $display("FAIL hold_fv: got %b expected %b", fetch_valid, DS_VALID); end
      tick();
      $display("stalled redirect: pc=%h", pc);
      checks++; if (pc !== 32'h4000_0108) begin errors++; $display("FAIL pend_pc: got %h expected %h", pc, 32'h4000_0108); end
      checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL after_hold_fv: got %b expected 1", fetch_valid); end
   endtask

   task automatic test_priority();
      jr = 1'b1; jump = 1'b1; branch_taken = 1'b1;
      jr_addr = 32'h103; jump_idx = 26'h3FF_FFFF; branch_off_sh = 32'h40;
      #1;
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL misalign_early: got %b expected 0", misalign); end
      tick();
      clear_redirects();
      #1;
      $display("priority: pc=%h misalign=%b", pc, misalign);
      checks++; if (pc !== 32'h100) begin errors++; $display("FAIL prio_pc: got %h expected %h", pc, 32'h100); end
      checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign_pulse: got %b expected 1", misalign); end
      tick();
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL misalign_clear: got %b expected 0", misalign); end
      checks++; if (pc !== 32'h104) begin errors++; $display("FAIL prio_seq: got %h expected %h", pc, 32'h104); end
   endtask

   task automatic test_no_advance();
      stall = 1'b1; imem_ready = 1'b1;
      #1;
      checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_ready_fv: got %b expected 0", fetch_valid); end
      tick();
      checks++; if (pc !== 32'h104) begin errors++; $display("FAIL stall_ready_pc: got %h expected %h", pc, 32'h104); end
      stall = 1'b0; imem_ready = 1'b0;
      tick();
      checks++; if (pc !== 32'h104) begin errors++; $display("FAIL not_ready_pc: got %h expected %h", pc, 32'h104); end
      imem_ready = 1'b1;
      tick();
      $display("no-advance: pc=%h", pc);
      checks++; if (pc !== 32'h108) begin errors++; $display("FAIL resume_pc: got %h expected %h", pc, 32'h108); end
   endtask

   task automatic test_wrap();
      jr = 1'b1; jr_addr = 32'hFFFF_FFFC;
      tick();
      clear_redirects();
      #1;
      checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got %h expected %h", pc, 32'hFFFF_FFFC); end
      checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h expected %h", pc_plus4, 32'h0); end
      tick();
      $display("wrap: pc=%h", pc);
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected %h", pc, 32'h0); end
   endtask

   task automatic test_reset_in_hold();
      stall = 1'b1; jump = 1'b1; jump_idx = 26'h0000100;
      tick();
      clear_redirects();
      rst = 1'b1; stall = 1'b0;
      tick();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_hold_pc: got %h expected %h", pc, 32'h0); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_hold_req: got %b expected 0", imem_req); end
      rst = 1'b0;
      tick();
      tick();
      $display("reset in hold: pc=%h", pc);
      checks++; if (pc !== 32'h4) begin errors++; $display("FAIL rst_discard: got %h expected %h", pc, 32'h4); end
   endtask

   initial begin
      test_reset();
      test_branch();
      test_jump();
      test_stalled_redirect();
      test_priority();
      test_no_advance();
      test_wrap();
      test_reset_in_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and fetch-sequencing stage of the MIPS32 datapath. It holds the PC and computes PC+4. It selects the next PC from sequential, branch, jump and register-jump sources, and drives a ready/request handshake toward instruction memory. It consumes the word-aligned branch offset produced by the shift-left-2 stage directly downstream of sign-extension.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word-aligned)
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  pipeline hold from hazard unit; blocks PC advance
- branch_taken  input  1  branch resolved taken this cycle
- branch_off_sh  input  32  sign-extended offset already shifted left by 2
- jump  input  1  J/JAL redirect this cycle
- jump_idx  input  26  instr_index field of J/JAL
- jr  input  1  JR/JALR redirect this cycle
- jr_addr  input  32  register target for JR/JALR
- imem_ready  input  1  instruction memory accepts/returns fetch this cycle
- imem_req  output  1  fetch request; address is pc
- pc  output  32  current fetch address
- pc_plus4  output  32  pc + 4, combinational
- fetch_valid  output  1  instruction returned this cycle is to be decoded
- misalign  output  1  one-cycle pulse: accepted jr target had nonzero [1:0]

## Operation
- FSM states: S_BOOT, S_FETCH, S_HOLD.
- S_BOOT: imem_req=0. Goes to S_FETCH after one cycle, or to S_HOLD if a redirect arrives in that cycle.
- S_FETCH: imem_req=1.
- advance = imem_req & imem_ready & !stall.
- Redirect priority: jr > jump > branch_taken. Lower-priority requests in the same cycle are ignored.
- Targets, all 32-bit with wrap-around modulo 2^32 and no overflow flag:
  - branch: pc + branch_off_sh. The base is the fetch pc in the sampling cycle, which equals branch PC+4.
  - jump: {pc[31:28], jump_idx, 2'b00}.
  - jr: {jr_addr[31:2], 2'b00}. If jr_addr[1:0]!=0, misalign is pulsed.
- Redirect with advance: pc <= target.
- Redirect without advance: the target is latched in pend_pc and the FSM goes to S_HOLD.
- S_HOLD: imem_req=1. On advance, pc <= pend_pc, then return to S_FETCH. A new redirect in S_HOLD overwrites pend_pc; newest wins.
- No redirect, advance: pc <= pc_plus4.
- No advance: pc holds.
- Squash: fetch_valid = advance & !kill. kill is set when a redirect is active this cycle (input or S_HOLD) and DELAY_SLOT_EN is undefined.

## Timing
- Reset values: pc=RESET_PC, imem_req=0, fetch_valid=0, misalign=0, state=S_BOOT, pend_pc=0.
- First imem_req=1 in the second cycle after rst deasserts.
- Redirect latency is one cycle: target appears on pc the edge after the accepting advance.
- pc_plus4 and fetch_valid are combinational from registered state and current inputs.
- misalign is registered and asserts the cycle after the jr is sampled.
- rst mid-operation discards any pending redirect, regardless of stall or imem_ready.
- stall=1 and imem_ready=1 together: no advance, fetch_valid=0.

## Configuration
- BRANCH_DELAY_SLOT_EN defined: the instruction fetched in the redirect-accepting cycle (the delay slot) keeps fetch_valid=1. This is MIPS architectural behaviour.
- Undefined: that instruction is squashed (fetch_valid=0). The target instruction is the next valid fetch.
- The PC sequence is identical in both builds.

## Structure
- Shared package mips_pkg holds:
  - fetch state enum (S_BOOT/S_FETCH/S_HOLD)
  - RESET_PC default constant
  - redirect-source encoding (NONE/BR/J/JR)
- Sub-module next_pc_sel: purely combinational priority mux and target arithmetic. Outputs target, redirect and misalign_raw. The parent owns all registers and the FSM.

## Test plan
- Reset: hold rst 3 cycles, release, imem_ready=1 -> pc=0x0, imem_req=0 one cycle, then pc steps 0x0, 0x4, 0x8 on consecutive cycles.
- Branch: at pc=0x8, branch_taken=1, branch_off_sh=0x10 -> next pc=0x18. fetch_valid=0 in that cycle, or 1 with BRANCH_DELAY_SLOT_EN.
- Jump: pc=0x4000_0010, jump=1, jump_idx=0x0000040 -> next pc=0x4000_0100.
- Stalled redirect: stall=1, jr=1, jr_addr=0x200 -> pc holds, S_HOLD. A branch next cycle with off 0x8 at pc P overwrites pend_pc. Release stall -> pc=P+8.
- Priority and misalign: jr=1, jump=1, branch_taken=1, jr_addr=0x103 -> pc=0x100, misalign=1 for exactly one cycle.
- Wrap: pc=0xFFFF_FFFC sequential -> pc=0x0. Assert rst while in S_HOLD -> pc=RESET_PC and the pending target is discarded.
